// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVING    = 2'd1,
        ST_DOOR_OPEN = 2'd2,
        ST_HALT      = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Index width for n items, never below one bit.
    function automatic int fw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_scan_tick_timer.sv
// Tick counter running 0..TICKS-1; done flags the terminal tick and the count wraps.
module tick_timer
    import elevator_pkg::*;
#(
    parameter int TICKS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    input  logic enable,
    output logic done
);
    localparam int CW = fw(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done = enable && !hold && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (done)
            cnt_d = '0;
        else if (enable && !hold)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/elevator_scan.sv
// SCAN elevator controller: latches floor calls, serves them in sweep order,
// with door timing, overweight hold and an emergency halt that freezes everything.
module elevator_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 4,
    parameter int MOVE_TICKS = 5,
    parameter int DOOR_TICKS = 2,
    localparam int FW        = fw(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] call,
    input  logic              sos,
    input  logic              overweight,
    output logic [FLOORS-1:0] led,
    output logic [FLOORS-1:0] floor_onehot,
    output logic [FW-1:0]     floor_idx,
    output logic              door,
    output logic              moving,
    output logic              dir_up,
    output logic              sos_mode,
    output logic              weight_limit_exceeded
);
    localparam logic [FW-1:0] LAST_FLOOR = FW'(FLOORS - 1);

    state_e            state_q, state_d, ret_q, ret_d;
    logic [FLOORS-1:0] req_q, req_d, onehot_q, onehot_d;
    logic [FW-1:0]     floor_q, floor_d, next_floor;
    logic              dir_q, dir_d, door_q, door_d, moving_q, moving_d;
    logic              sos_mode_q, sos_mode_d, wle_q, wle_d;
    logic              freeze, call_here, move_done, door_done, move_clear, door_clear;

    // Floors strictly beyond f in the given direction.
    function automatic logic [FLOORS-1:0] ahead_mask(input logic [FW-1:0] f, input logic up);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++)
            m[i] = up ? (i > int'(f)) : (i < int'(f));
        return m;
    endfunction

    assign freeze     = sos || (state_q == ST_HALT);
    assign call_here  = call[floor_q];
    assign move_clear = !freeze && (state_q != ST_MOVING);
    // A call at this floor or a heavy load keeps the door timer pinned at zero.
    assign door_clear = !freeze && ((state_q != ST_DOOR_OPEN) || call_here || overweight);
    assign next_floor = (dir_q == DIR_UP) ? ((floor_q == LAST_FLOOR) ? floor_q : floor_q + 1'b1)
                                          : ((floor_q == '0) ? floor_q : floor_q - 1'b1);

    tick_timer #(.TICKS(MOVE_TICKS)) u_move_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (move_clear),
        .hold   (freeze),
        .enable (state_q == ST_MOVING),
        .done   (move_done)
    );

    tick_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (door_clear),
        .hold   (freeze),
        .enable (state_q == ST_DOOR_OPEN),
        .done   (door_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            req_q      <= '0;
            floor_q    <= '0;
            onehot_q   <= FLOORS'(1);
            dir_q      <= DIR_UP;
            door_q     <= 1'b0;
            moving_q   <= 1'b0;
            sos_mode_q <= 1'b0;
            wle_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            req_q      <= req_d;
            floor_q    <= floor_d;
            onehot_q   <= onehot_d;
            dir_q      <= dir_d;
            door_q     <= door_d;
            moving_q   <= moving_d;
            sos_mode_q <= sos_mode_d;
            wle_q      <= wle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        req_d   = req_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        if (sos) begin
            if (state_q != ST_HALT) begin
                state_d = ST_HALT;
                ret_d   = state_q;
            end
        end else begin
            unique case (state_q)
                ST_HALT: state_d = ret_q;
                ST_IDLE: begin
                    req_d = req_q | (call & ~onehot_q);
                    if (call_here || req_q[floor_q]) begin
                        req_d[floor_q] = 1'b0;
                        state_d        = ST_DOOR_OPEN;
                    end else if (!overweight && (req_q != '0)) begin
                        state_d = ST_MOVING;
                        dir_d   = ((req_q & ahead_mask(floor_q, dir_q)) != '0) ? dir_q :
                                  ((dir_q == DIR_UP) ? DIR_DOWN : DIR_UP);
                    end
                end
                ST_MOVING: begin
                    req_d = req_q | call;
                    if (move_done) begin
                        floor_d = next_floor;
                        if (req_q[next_floor]) begin
                            req_d[next_floor] = 1'b0;
                            state_d           = ST_DOOR_OPEN;
                        end else if ((req_q & ahead_mask(next_floor, dir_q)) == '0) begin
                            // Nothing left ahead: stop and let IDLE pick a new sweep.
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DOOR_OPEN: begin
                    req_d = req_q | (call & ~onehot_q);
                    if (!call_here && door_done)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        moving_d   = (state_d == ST_MOVING);
        door_d     = (state_d == ST_DOOR_OPEN) || ((state_d == ST_HALT) && door_q);
        sos_mode_d = (state_d == ST_HALT);
        wle_d      = overweight;
        onehot_d   = '0;
        onehot_d[floor_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset && move_done)
            assert ((dir_q == DIR_UP) ? (floor_q != LAST_FLOOR) : (floor_q != '0));
    end

    assign led                   = req_q;
    assign floor_onehot          = onehot_q;
    assign floor_idx             = floor_q;
    assign door                  = door_q;
    assign moving                = moving_q;
    assign dir_up                = dir_q;
    assign sos_mode              = sos_mode_q;
    assign weight_limit_exceeded = wle_q;

endmodule
